// File: rtl/data_mem_resp_pkg.sv
// Shared widths, depths and types for the data-memory responder.
// The store queue holds word indices, not full addresses.
package data_mem_resp_pkg;

   localparam int WORD_SIZE_P = 16;
   localparam int MEM_WORDS_P = 256;
   localparam int WQ_DEPTH_P  = 4;

   localparam int MEM_IDX_W   = $clog2(MEM_WORDS_P);
   localparam int WQ_PTR_W    = $clog2(WQ_DEPTH_P);
   localparam int WQ_CNT_W    = WQ_PTR_W + 1;

   typedef struct packed {
      logic [MEM_IDX_W-1:0]   idx;
      logic [WORD_SIZE_P-1:0] data;
   } mem_wq_entry_t;

   // Where the registered load response takes its data from.
   typedef enum logic {
      SRC_RAM = 1'b0,
      SRC_FWD = 1'b1
   } ld_src_e;

endpackage

// File: rtl/data_mem_resp_sram.sv
// Single-port synchronous data RAM: one read or one write per cycle.
// Read data appears the cycle after the request and holds until the next read.
module dmem_sram
   import data_mem_resp_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   en,
   input  logic                   we,
   input  logic [MEM_IDX_W-1:0]   idx,
   input  logic [WORD_SIZE_P-1:0] wdata,
   output logic [WORD_SIZE_P-1:0] rdata
);

   logic [WORD_SIZE_P-1:0] mem_array [MEM_WORDS_P];

   always_ff @(posedge clk_i) begin
      if (en) begin
         if (we) begin
            mem_array[idx] <= wdata;
         end else begin
            rdata <= mem_array[idx];
         end
      end
   end

endmodule

// File: rtl/data_mem_resp.sv
// Store write queue draining into a single-port RAM, with a 1-cycle load port that
// forwards from the same-cycle store or the youngest matching queued store.
module data_mem_resp
   import data_mem_resp_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   sb_mem_v_i,
   input  logic [WORD_SIZE_P-1:0] sb_mem_addr_i,
   input  logic [WORD_SIZE_P-1:0] sb_mem_data_i,
   input  logic                   rob_mispredict_i,
   input  logic                   exe_mem_ld_v_i,
   input  logic [WORD_SIZE_P-1:0] exe_mem_ld_addr_i,
   output logic                   mem_ld_ready_o,
   output logic                   mem_exe_ld_v_o,
   output logic [WORD_SIZE_P-1:0] mem_exe_ld_data_o,
   output logic                   mem_wq_empty_o
);

   mem_wq_entry_t          wq_reg [WQ_DEPTH_P];
   logic [WQ_PTR_W-1:0]    head_reg, tail_reg;
   logic [WQ_CNT_W-1:0]    count_reg;

   logic                   ld_v_reg;
   ld_src_e                ld_src_reg;
   logic [WORD_SIZE_P-1:0] fwd_data_reg;

   logic [MEM_IDX_W-1:0]   st_idx, ld_idx;
   logic                   ld_acc, drain, st_hit, q_hit;
   logic [WORD_SIZE_P-1:0] q_data, fwd_data_next, ram_rdata;
   logic                   unused_addr_hi;

   assign st_idx         = sb_mem_addr_i[MEM_IDX_W-1:0];
   assign ld_idx         = exe_mem_ld_addr_i[MEM_IDX_W-1:0];
   assign unused_addr_hi = ^{sb_mem_addr_i[WORD_SIZE_P-1:MEM_IDX_W],
                             exe_mem_ld_addr_i[WORD_SIZE_P-1:MEM_IDX_W]};

   // A full queue refuses loads so the RAM port is free to drain, which keeps stores from overflowing.
   assign mem_ld_ready_o = (count_reg != WQ_CNT_W'(WQ_DEPTH_P)) && !rob_mispredict_i;
   assign ld_acc         = exe_mem_ld_v_i && mem_ld_ready_o;
   assign drain          = (count_reg != '0) && !ld_acc;
   assign mem_wq_empty_o = (count_reg == '0);

   // Age gi = 0 is the youngest entry (tail-1); only ages below count are live.
   logic [WQ_PTR_W-1:0]   age_slot [WQ_DEPTH_P];
   logic [WQ_DEPTH_P-1:0] age_match;

   for (genvar gi = 0; gi < WQ_DEPTH_P; gi++) begin : g_age
      assign age_slot[gi]  = tail_reg - WQ_PTR_W'(gi + 1);
      assign age_match[gi] = (WQ_CNT_W'(gi) < count_reg) && (wq_reg[age_slot[gi]].idx == ld_idx);
   end

   always_comb begin
      q_hit  = 1'b0;
      q_data = '0;
      for (int k = WQ_DEPTH_P - 1; k >= 0; k--) begin
         if (age_match[k]) begin
            q_hit  = 1'b1;
            q_data = wq_reg[age_slot[k]].data;
         end
      end
   end

   assign st_hit        = sb_mem_v_i && (st_idx == ld_idx);
   assign fwd_data_next = st_hit ? sb_mem_data_i : q_data;

   dmem_sram u_sram (
      .clk_i (clk_i),
      .en    (ld_acc || drain),
      .we    (drain),
      .idx   (drain ? wq_reg[head_reg].idx : ld_idx),
      .wdata (wq_reg[head_reg].data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (sb_mem_v_i) begin
         wq_reg[tail_reg] <= '{idx: st_idx, data: sb_mem_data_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         ld_v_reg     <= 1'b0;
         ld_src_reg   <= SRC_FWD;
         fwd_data_reg <= '0;
      end else begin
         if (sb_mem_v_i) tail_reg <= tail_reg + 1'b1;
         if (drain)      head_reg <= head_reg + 1'b1;
         count_reg <= count_reg + WQ_CNT_W'(sb_mem_v_i) - WQ_CNT_W'(drain);
         ld_v_reg  <= ld_acc;
         if (ld_acc) begin
            ld_src_reg   <= (st_hit || q_hit) ? SRC_FWD : SRC_RAM;
            fwd_data_reg <= fwd_data_next;
         end
      end
   end

   // A mispredict also kills the response already in flight this cycle.
   assign mem_exe_ld_v_o    = ld_v_reg && !rob_mispredict_i;
   assign mem_exe_ld_data_o = (ld_src_reg == SRC_RAM) ? ram_rdata : fwd_data_reg;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed table, queue-full and flush sequences, then random traffic
// checked against an architectural memory image plus a pending-store count.
module tb_data_mem_resp;
   import data_mem_resp_pkg::*;

   logic        clk = 1'b0;
   logic        srst;
   logic        sb_v, mp, ld_v;
   logic [15:0] sb_addr, sb_data, ld_addr;
   logic        ld_ready, rsp_v, wq_empty;
   logic [15:0] rsp_data;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference state: memory as seen by program order, stores still pending, last response.
   logic [15:0] arch_mem [256];
   int          pend_cnt;
   logic        exp_pend_v;
   logic [15:0] exp_data;

   typedef struct {
      logic        sv;
      logic [15:0] sa;
      logic [15:0] sd;
      logic        mp;
      logic        lv;
      logic [15:0] la;
      bit          chk;
      logic        er;
      logic        ev;
      logic [15:0] ed;
   } vec_t;

   vec_t tab[$];

   always #5 clk = ~clk;

   data_mem_resp dut (
      .clk_i             (clk),
      .reset_i           (srst),
      .sb_mem_v_i        (sb_v),
      .sb_mem_addr_i     (sb_addr),
      .sb_mem_data_i     (sb_data),
      .rob_mispredict_i  (mp),
      .exe_mem_ld_v_i    (ld_v),
      .exe_mem_ld_addr_i (ld_addr),
      .mem_ld_ready_o    (ld_ready),
      .mem_exe_ld_v_o    (rsp_v),
      .mem_exe_ld_data_o (rsp_data),
      .mem_wq_empty_o    (wq_empty)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // One clock: drive at posedge+1, compare on the falling edge, advance the reference model.
   task automatic cycle(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                        input logic m, input logic lv, input logic [15:0] la,
                        input bit chk, input logic er, input logic ev, input logic [15:0] ed);
      logic m_ready, acc;
      sb_v = sv; sb_addr = sa; sb_data = sd; mp = m; ld_v = lv; ld_addr = la;
      @(negedge clk);
      m_ready = (pend_cnt != WQ_DEPTH_P) && !m;
      check("ready", 16'(ld_ready), 16'(m_ready));
      check("wq_empty", 16'(wq_empty), 16'(pend_cnt == 0));
      check("rsp_v", 16'(rsp_v), 16'(exp_pend_v && !m));
      check("rsp_data", rsp_data, exp_data);
      if (chk) begin
         check("tab_ready", 16'(ld_ready), 16'(er));
         check("tab_v", 16'(rsp_v), 16'(ev));
         check("tab_data", rsp_data, ed);
      end
      acc = lv && m_ready;
      if (sv) arch_mem[sa[7:0]] = sd;
      exp_pend_v = acc;
      if (acc) begin
         exp_data = arch_mem[la[7:0]];
         $display("load addr=%h expect=%h (store_v=%0b mp=%0b pending=%0d)", la, exp_data, sv, m, pend_cnt);
      end
      if (pend_cnt != 0 && !acc) pend_cnt--;
      if (sv) pend_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
   endtask

   task automatic drain_all();
      for (int i = 0; i < 8 && pend_cnt != 0; i++) idle(1);
      check("drained", 16'(pend_cnt), 16'd0);
   endtask

   task automatic add(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                      input logic m, input logic lv, input logic [15:0] la,
                      input bit chk, input logic er, input logic ev, input logic [15:0] ed);
      vec_t v;
      v.sv = sv; v.sa = sa; v.sd = sd; v.mp = m; v.lv = lv; v.la = la;
      v.chk = chk; v.er = er; v.ev = ev; v.ed = ed;
      tab.push_back(v);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) arch_mem[i] = 16'h0;
      sb_v = 0; sb_addr = 0; sb_data = 0; mp = 0; ld_v = 0; ld_addr = 0;
      srst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      srst = 1'b0;
      pend_cnt = 0; exp_pend_v = 1'b0; exp_data = 16'h0;

      // sv  sa       sd       mp lv la      chk er ev ed
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 16'h0000); // reset state
      add(1, 16'h0005, 16'h1234, 0, 0, 16'h0000, 1, 1, 0, 16'h0000); // preload 5 via queue
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 16'h0000, 16'h0000, 0, 1, 16'h0005, 1, 1, 0, 16'h0000); // load from RAM
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 16'h1234);
      add(1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 16'h0000, 16'h0000, 0, 1, 16'h0010, 1, 1, 0, 16'h1234); // queue forward
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 16'hBEEF);
      add(1, 16'h0020, 16'h1111, 0, 1, 16'h0020, 0, 0, 0, 16'h0000); // same-cycle forward
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 16'h1111);
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 16'h0000, 16'h0000, 0, 1, 16'h7F20, 0, 0, 0, 16'h0000); // RAM, upper addr bits ignored
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 16'h1111);
      add(1, 16'h0030, 16'hAAAA, 0, 1, 16'h0005, 0, 0, 0, 16'h0000); // loads block drain
      add(1, 16'h0030, 16'hBBBB, 0, 1, 16'h0005, 1, 1, 1, 16'h1234);
      add(0, 16'h0000, 16'h0000, 0, 1, 16'h0030, 1, 1, 1, 16'h1234); // youngest of two
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 16'hBBBB);
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 16'h0000, 16'h0000, 0, 1, 16'h0010, 0, 0, 0, 16'h0000); // accepted in N
      add(1, 16'h0040, 16'h4444, 1, 1, 16'h0010, 1, 0, 0, 16'hBEEF); // mispredict in N+1
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 16'hBEEF);
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 16'h0000, 16'h0000, 0, 1, 16'h0040, 0, 0, 0, 16'h0000); // flushed-cycle store landed
      add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 16'h4444);

      foreach (tab[i])
         cycle(tab[i].sv, tab[i].sa, tab[i].sd, tab[i].mp, tab[i].lv, tab[i].la,
               tab[i].chk, tab[i].er, tab[i].ev, tab[i].ed);
      drain_all();

      // Loads held valid while five stores arrive: the fifth sees a full queue.
      for (int k = 0; k < 6; k++) begin
         if (k < 4)
            cycle(1, 16'h0050 + 16'(k), 16'h5000 + 16'(k), 0, 1, 16'h0005, 0, 0, 0, 16'h0);
         else if (k == 4)
            cycle(1, 16'h0054, 16'h5004, 0, 1, 16'h0005, 1, 0, 1, 16'h1234);
         else
            cycle(0, 16'h0000, 16'h0000, 0, 1, 16'h0005, 1, 0, 0, 16'h1234);
      end
      drain_all();
      for (int k = 0; k < 5; k++) cycle(0, 16'h0, 16'h0, 0, 1, 16'h0050 + 16'(k), 0, 0, 0, 16'h0);
      cycle(0, 16'h0, 16'h0, 0, 0, 16'h0, 1, 1, 1, 16'h5004);

      // Random traffic over a small set of pre-written indices to stress forwarding.
      for (int i = 0; i < 16; i++)
         cycle(1, {8'($urandom), 8'(i)}, 16'($urandom), 0, 0, 16'h0, 0, 0, 0, 16'h0);
      drain_all();
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 1) == 1, {8'($urandom), 8'($urandom_range(0, 15))}, 16'($urandom),
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
               {8'($urandom), 8'($urandom_range(0, 15))}, 0, 0, 0, 16'h0);
      end
      drain_all();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
